// File: rtl/tt_scan_pkg.sv
// Shared types and helpers for the truth-table scanner: FSM state encoding,
// settle-counter width and the 2^n table-width helper.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  localparam int SETTLE_W = 4;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_scanner_if.sv
// Bus between the scanner and the expression under test.
// TT_SCAN_CHECK_EN adds the expected/match/fail_idx signals.
interface tt_scanner_if
  import tt_scan_pkg::*;
#(
  parameter int N_IN = 4
);
  localparam int TW = tt_w(N_IN);

  logic            start;
  logic [N_IN-1:0] vars;
  logic            f_in;
  logic            busy;
  logic            done;
  logic [TW-1:0]   tt_table;
  logic [N_IN:0]   ones;
`ifdef TT_SCAN_CHECK_EN
  logic [TW-1:0]   expected;
  logic            match;
  logic [N_IN-1:0] fail_idx;
`endif

  modport master (
`ifdef TT_SCAN_CHECK_EN
    output expected,
    input  match, fail_idx,
`endif
    output start, f_in,
    input  vars, busy, done, tt_table, ones
  );

  modport slave (
`ifdef TT_SCAN_CHECK_EN
    input  expected,
    output match, fail_idx,
`endif
    input  start, f_in,
    output vars, busy, done, tt_table, ones
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that paces the SETTLE state; zero_o marks expiry.
module tt_settle_timer
  import tt_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_scanner.sv
// Walks an expression through every input combination and collects f into a
// minterm table plus ones count. Optional self-check: TT_SCAN_CHECK_EN.
module tt_scanner
  import tt_scan_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  tt_scanner_if.slave  bus
);

  localparam int TW = tt_w(N_IN);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;
  localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [1:0] S_DONE   = ST_DONE;
  localparam logic [1:0] S_NEXT_IDX = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(TW - 1);
  // The timer is loaded with SETTLE-1 so SETTLE cycles are spent in SETTLE.
  localparam logic [SETTLE_W-1:0] SETTLE_LD = (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN-1:0] vars_q, vars_d;
  logic            clear, sample, tmr_load, tmr_dec, tmr_zero;

  tt_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    clear    = 1'b0;
    sample   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clear    = 1'b1;
          idx_d    = '0;
          ones_d   = '0;
          tmr_load = 1'b1;
          state_d  = S_NEXT_IDX;
        end
      end
      S_SETTLE: begin
        if (tmr_zero) state_d = S_SAMPLE;
        else          tmr_dec = 1'b1;
      end
      S_SAMPLE: begin
        sample = 1'b1;
        if (bus.f_in) ones_d = ones_q + (N_IN+1)'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + (N_IN+1)'(1);
          tmr_load = 1'b1;
          state_d  = S_NEXT_IDX;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < TW; gi++) begin : g_tbl
    assign table_d[gi] = clear ? 1'b0 :
                         (sample && (idx_q == (N_IN+1)'(gi))) ? bus.f_in : table_q[gi];
  end

  assign vars_d = ((state_d == S_SETTLE) || (state_d == S_SAMPLE)) ? idx_d[N_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ones_q  <= '0;
      table_q <= '0;
      vars_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      table_q <= table_d;
      vars_q  <= vars_d;
    end
  end

  assign bus.vars     = vars_q;
  assign bus.busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.tt_table = table_q;
  assign bus.ones     = ones_q;

`ifdef TT_SCAN_CHECK_EN
  logic [TW-1:0]   expected_q, diff;
  logic            match_q;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;

  // Lowest differing index wins, so scan from the top down.
  always_comb begin
    diff       = table_d ^ expected_q;
    fail_idx_d = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff[i]) fail_idx_d = N_IN'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expected_q <= '0;
      match_q    <= 1'b0;
      fail_idx_q <= '0;
    end else if (clear) begin
      expected_q <= bus.expected;
      match_q    <= 1'b0;
      fail_idx_q <= '0;
    end else if (sample && (idx_q == IDX_LAST)) begin
      match_q    <= (diff == '0);
      fail_idx_q <= fail_idx_d;
    end
  end

  assign bus.match    = match_q;
  assign bus.fail_idx = fail_idx_q;
`endif

endmodule
